// File: rtl/smc_pkg.sv
// Shared constants, state encoding and reduction weights for the smc_calc_seq sequencer.
// Weights apply only when SMC_WEIGHTED_SUM_EN is defined.
package smc_pkg;
  localparam int N_CH  = 6;
  localparam int DW    = 3;
  localparam int OW    = 10;
  localparam int IDX_W = 3;

  localparam int MODE_ID_BIT  = 0;
  localparam int MODE_MAX_BIT = 1;

  localparam int WGT_R0 = 3;
  localparam int WGT_R1 = 4;
  localparam int WGT_R2 = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/smc_calc_unit.sv
// Combinational MOSFET Id/gm evaluator, triode or saturation selected by v = Vgs-1 versus Vds.
module smc_calc_unit
  import smc_pkg::*;
(
  input  logic [DW-1:0] Vgs,
  input  logic [DW-1:0] Vds,
  input  logic [DW-1:0] W,
  output logic [OW-1:0] Id,
  output logic [OW-1:0] gm
);
  logic [OW-1:0] v;
  logic [OW-1:0] vds;
  logic [OW-1:0] w;
  logic [OW-1:0] id_num;
  logic [OW-1:0] gm_num;

  always_comb begin
    v   = OW'(Vgs) - OW'(1);
    vds = OW'(Vds);
    w   = OW'(W);
    // The triode numerator is non-negative because v > vds on that branch.
    if (v > vds) begin
      id_num = w * ((OW'(2) * v * vds) - (vds * vds));
      gm_num = OW'(2) * w * vds;
    end else begin
      id_num = w * v * v;
      gm_num = OW'(2) * w * v;
    end
    Id = id_num / OW'(3);
    gm = gm_num / OW'(3);
  end
endmodule

// File: rtl/smc_calc_seq.sv
// Loads N_CH channels serially, evaluates them through one shared calc unit and reduces the three
// most extreme results. Define SMC_WEIGHTED_SUM_EN for the 3/4/5 weighted reduction.
module smc_calc_seq
  import smc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] Vgs,
  input  logic [DW-1:0] Vds,
  input  logic [DW-1:0] W,
  output logic          out_valid,
  output logic [OW-1:0] out_n,
  output logic          busy
);
  state_t        state;
  state_t        state_nxt;
  logic [IDX_W-1:0] idx;
  logic [1:0]    mode_r;
  logic [DW-1:0] rf_vgs [N_CH];
  logic [DW-1:0] rf_vds [N_CH];
  logic [DW-1:0] rf_w   [N_CH];
  logic [OW-1:0] r0, r1, r2;
  logic [OW-1:0] r0_nxt, r1_nxt, r2_nxt;
  logic [OW-1:0] calc_id, calc_gm, cand;
  logic          last_idx;
  logic          max_mode;

  function automatic logic better(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                  input logic is_max);
    return is_max ? (a > b) : (a < b);
  endfunction

  function automatic logic [OW-1:0] reduce3(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                            input logic [OW-1:0] c);
`ifdef SMC_WEIGHTED_SUM_EN
    return OW'(WGT_R0) * a + OW'(WGT_R1) * b + OW'(WGT_R2) * c;
`else
    return a + b + c;
`endif
  endfunction

  assign last_idx = (idx == IDX_W'(N_CH - 1));
  assign max_mode = mode_r[MODE_MAX_BIT];

  smc_calc_unit u_calc (
    .Vgs (rf_vgs[idx]),
    .Vds (rf_vds[idx]),
    .W   (rf_w[idx]),
    .Id  (calc_id),
    .gm  (calc_gm)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    out_valid = (state == OUT);
    out_n     = '0;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: begin
        if (!in_valid)     state_nxt = IDLE;
        else if (last_idx) state_nxt = CALC;
      end
      CALC: if (last_idx) state_nxt = OUT;
      OUT: begin
        state_nxt = IDLE;
        out_n     = reduce3(r0, r1, r2);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strict compare: an equal candidate slides below existing entries rather than displacing them.
  always_comb begin
    cand   = mode_r[MODE_ID_BIT] ? calc_id : calc_gm;
    r0_nxt = r0;
    r1_nxt = r1;
    r2_nxt = r2;
    if (better(cand, r0, max_mode)) begin
      r0_nxt = cand;
      r1_nxt = r0;
      r2_nxt = r1;
    end else if (better(cand, r1, max_mode)) begin
      r1_nxt = cand;
      r2_nxt = r1;
    end else if (better(cand, r2, max_mode)) begin
      r2_nxt = cand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      mode_r <= '0;
      r0     <= '0;
      r1     <= '0;
      r2     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rf_vgs[i] <= '0;
        rf_vds[i] <= '0;
        rf_w[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rf_vgs[0] <= Vgs;
            rf_vds[0] <= Vds;
            rf_w[0]   <= W;
            mode_r    <= mode;
            idx       <= IDX_W'(1);
          end
        end
        LOAD: begin
          if (!in_valid) begin
            idx <= '0;
          end else begin
            rf_vgs[idx] <= Vgs;
            rf_vds[idx] <= Vds;
            rf_w[idx]   <= W;
            if (last_idx) begin
              idx <= '0;
              r0  <= max_mode ? '0 : '1;
              r1  <= max_mode ? '0 : '1;
              r2  <= max_mode ? '0 : '1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        CALC: begin
          r0  <= r0_nxt;
          r1  <= r1_nxt;
          r2  <= r2_nxt;
          idx <= last_idx ? '0 : idx + IDX_W'(1);
        end
        OUT: begin
          r0 <= '0;
          r1 <= '0;
          r2 <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_smc_calc_seq.sv
// Scoreboard bench for smc_calc_seq: directed reference frame plus randomized frames against a sorting model.
module tb_smc_calc_seq;
  import smc_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] Vgs = '0;
  logic [DW-1:0] Vds = '0;
  logic [DW-1:0] W = '0;
  logic          out_valid;
  logic [OW-1:0] out_n;
  logic          busy;

  always #5 clk = ~clk;

  smc_calc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mode      (mode),
    .Vgs       (Vgs),
    .Vds       (Vds),
    .W         (W),
    .out_valid (out_valid),
    .out_n     (out_n),
    .busy      (busy)
  );

`ifdef SMC_WEIGHTED_SUM_EN
  localparam int E11 = 489, E01 = 114, E10 = 194, E00 = 59;
`else
  localparam int E11 = 134, E01 = 24,  E10 = 52,  E00 = 13;
`endif

  typedef struct {
    int value;
    int at_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   fv[N_CH];
  int   fd[N_CH];
  int   fw[N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic int calc(int vg, int vd, int w, bit want_id);
    int v;
    v = vg - 1;
    if (v > vd) return want_id ? w * (2 * v * vd - vd * vd) / 3 : 2 * w * vd / 3;
    return want_id ? w * v * v / 3 : 2 * w * v / 3;
  endfunction

  // Sort the six results toward the selected extreme and reduce the first three.
  function automatic int model(logic [1:0] md);
    int a[N_CH];
    int t;
    for (int i = 0; i < N_CH; i++) a[i] = calc(fv[i], fd[i], fw[i], md[0]);
    for (int i = 0; i < N_CH - 1; i++)
      for (int j = 0; j < N_CH - 1 - i; j++)
        if (md[1] ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
`ifdef SMC_WEIGHTED_SUM_EN
    return 3 * a[0] + 4 * a[1] + 5 * a[2];
`else
    return a[0] + a[1] + a[2];
`endif
  endfunction

  task automatic set_frame_f();
    fv = '{5, 2, 6, 4, 5, 7};
    fd = '{6, 6, 7, 2, 3, 6};
    fw = '{7, 7, 3, 1, 4, 6};
  endtask

  task automatic set_frame_rand();
    for (int i = 0; i < N_CH; i++) begin
      fv[i] = int'($urandom_range(7, 1));
      fd[i] = int'($urandom_range(7, 0));
      fw[i] = int'($urandom_range(7, 0));
    end
  endtask

  // Called #1 after the edge opening the first word's cycle; returns #1 into the cycle after the last word.
  task automatic drive_frame(input logic [1:0] md, input int nw, input bit push, input int exp_val);
    for (int i = 0; i < nw; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        check("busy_load", busy, 1);
      end
      in_valid = 1'b1;
      mode     = (i == 0) ? md : ~md;
      Vgs      = DW'(fv[i]);
      Vds      = DW'(fd[i]);
      W        = DW'(fw[i]);
    end
    if (push) sb_q.push_back('{exp_val, cyc + 7});
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = 2'($urandom);
    Vgs      = DW'($urandom);
    Vds      = DW'($urandom);
    W        = DW'($urandom);
  endtask

  task automatic await_idle();
    for (int i = 0; i < 7; i++) begin
      check("busy_active", busy, 1);
      @(posedge clk); #1;
    end
    check("busy_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_n", int'(out_n), e.value);
          check("out_latency_cycle", cyc, e.at_cyc);
        end
      end else begin
        check("out_n_zero_when_invalid", int'(out_n), 0);
      end
    end
  end

  initial begin
    int md;
    int nw;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_n", int'(out_n), 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Reference frame in all four modes, each starting on the first IDLE cycle.
    set_frame_f();
    drive_frame(2'b11, N_CH, 1'b1, E11); await_idle();
    drive_frame(2'b01, N_CH, 1'b1, E01); await_idle();
    drive_frame(2'b10, N_CH, 1'b1, E10); await_idle();
    drive_frame(2'b00, N_CH, 1'b1, E00); await_idle();
    drive_frame(2'b11, N_CH, 1'b1, E11); await_idle();
    drive_frame(2'b11, N_CH, 1'b1, E11); await_idle();

    // Partial frame is discarded.
    drive_frame(2'b11, 3, 1'b0, 0);
    check("busy_partial_drop", busy, 1);
    @(posedge clk); #1;
    check("busy_after_partial", busy, 0);
    drive_frame(2'b10, N_CH, 1'b1, E10); await_idle();

    // Reset during CALC aborts the frame.
    drive_frame(2'b11, N_CH, 1'b0, 0);
    @(posedge clk); #3;
    check("busy_in_calc", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_n", int'(out_n), 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    drive_frame(2'b01, N_CH, 1'b1, E01); await_idle();

    // Randomized frames, some truncated, with random idle gaps.
    for (int f = 0; f < 30; f++) begin
      set_frame_rand();
      md = int'($urandom_range(3, 0));
      if ($urandom_range(4, 0) == 0) begin
        nw = int'($urandom_range(N_CH - 1, 1));
        drive_frame(2'(md), nw, 1'b0, 0);
        @(posedge clk); #1;
        check("busy_after_rand_partial", busy, 0);
      end else begin
        drive_frame(2'(md), N_CH, 1'b1, model(2'(md)));
        await_idle();
      end
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/smc_calc_seq.md
Name: smc_calc_seq

Overview:
- Sequencer that time-shares one MOSFET Id/gm calculation unit across N_CH transistor channels.
- Channels are loaded serially: one channel per cycle on a valid strobe.
- Each channel is evaluated through the shared unit, one per cycle, while a running tracker keeps the three most extreme results.
- Emits a single-cycle reduced result, sum of the selected three. Sits between the SMC input stimulus and the result checker.

Parameters:
- N_CH, 6, number of channels per frame; 6 is the only supported value.
- DW, 3, width of Vgs, Vds and W.
- OW, 10, width of out_n and of all result/accumulator registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  high for N_CH consecutive cycles; each cycle carries one channel, channel 0 first.
- mode  input  2  sampled on the first in_valid cycle only. mode[0]: 1=Id, 0=gm. mode[1]: 1=three largest, 0=three smallest.
- Vgs  input  DW  gate-source voltage, legal 1..7.
- Vds  input  DW  drain-source voltage, legal 0..7.
- W  input  DW  width, legal 0..7.
- out_valid  output  1  one-cycle result strobe.
- out_n  output  OW  reduced result; 0 whenever out_valid=0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous, active-low. While reset=0:
  - state=IDLE; out_valid=0, out_n=0, busy=0.
  - Channel register file, index counter, mode register and tracker all clear to 0.
  - Reset asserted mid-frame aborts the frame with no output.
- FSM states: IDLE, LOAD, CALC, OUT.
  - IDLE: in_valid=1 stores channel 0, latches mode, sets idx=1, goes to LOAD.
  - LOAD: in_valid=1 stores channel idx and increments idx. After channel N_CH-1 is stored: idx=0, go to CALC.
  - LOAD, in_valid=0 before N_CH words: partial frame discarded, return to IDLE, no out_valid.
  - CALC: each cycle the shared unit evaluates channel idx and the tracker updates at the clock edge. After idx=N_CH-1, go to OUT.
  - OUT: out_valid=1, out_n=reduction of the tracker, then IDLE. Tracker clears on entry to IDLE.
  - in_valid in CALC or OUT is ignored. A new frame may start on the first IDLE cycle.
- Latency: last in_valid cycle T. CALC covers T+1..T+6. out_valid is high at T+7.
- Calc unit arithmetic, with v=Vgs-1 and integer floor division by 3:
  - Triode, when v>Vds: Id = W*(2*v*Vds - Vds*Vds)/3, gm = 2*W*Vds/3.
  - Otherwise (saturation): Id = W*v*v/3, gm = 2*W*v/3.
  - Intermediates are OW bits; maximum single result is 84. Vgs=0 is illegal and its result is don't-care.
- Tracker: three registers r0,r1,r2, with r0 the most extreme.
  - Max mode initialises to 0; min mode initialises to all-ones.
  - Insertion uses strict compare: an equal value never displaces an existing entry.
- Reduction: out_n = r0+r1+r2, maximum 252.

Optional Feature:
- Macro: SMC_WEIGHTED_SUM_EN.
- Defined: out_n = 3*r0 + 4*r1 + 5*r2, maximum 1008, fits OW.
- Undefined: plain sum as above.
- Latency is identical in both builds.

Decomposition:
- Package smc_pkg holds:
  - constants N_CH, DW, OW;
  - state enum (IDLE, LOAD, CALC, OUT);
  - mode bit positions MODE_ID_BIT and MODE_MAX_BIT;
  - weights 3/4/5.
- One sub-module, smc_calc_unit: combinational (Vgs, Vds, W) -> (Id, gm), instantiated exactly once.
- FSM, register file, tracker and reduction stay in smc_calc_seq.

Test Plan:
Common frame F for tests 1-4: Vgs=(5,2,6,4,5,7), Vds=(6,6,7,2,3,6), W=(7,7,3,1,4,6). Per-channel Id=(37,2,25,2,20,72), gm=(18,4,10,1,8,24).
1. F, mode=2'b11 -> out_valid exactly 7 cycles after last in_valid; out_n=134 (72+37+25). With SMC_WEIGHTED_SUM_EN: 489.
2. F, mode=2'b01 -> out_n=24 (2+2+20), exercising tie insertion. Weighted: 114.
3. F, mode=2'b10 -> 52 (24+18+10); F, mode=2'b00 -> 13 (1+4+8).
4. F sent twice back-to-back, second frame starting on the first IDLE cycle, with mode changed on non-first cycles -> both outputs correct. Mode is latched only on the first cycle; busy tracks states.
5. in_valid dropped after 3 words -> no out_valid, busy=0 the next cycle. A full frame afterwards gives the correct result.
6. reset pulsed low during CALC -> outputs 0 asynchronously, no out_valid. The next frame is correct.
